// File: rtl/alu_pkg.sv
// Shared types and defaults for the sequential ALU and its multiply datapath.
package alu_pkg;

    localparam int DATA_W_DEFAULT = 16;

    // Operation codes presented on op together with start.
    // 3'b110 and 3'b111 are reserved; they hold result/carry but still pulse done.
    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_MUL  = 3'b011,
        OP_INC  = 3'b100,
        OP_CLR  = 3'b101
    } alu_op_t;

    // Controller states: waiting for a request, or iterating a multiply.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier datapath: one partial product per step.
// The controlling FSM lives in seq_alu; this block only holds operand,
// product and iteration-count registers.
module seq_mul #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_W-1:0]     a_in,
    input  logic [DATA_W-1:0]     b_in,
    output logic [2*DATA_W-1:0]   product_next,
    output logic                  last
);

    logic [2*DATA_W-1:0] mcand_reg;
    logic [DATA_W-1:0]   mplier_reg;
    logic [2*DATA_W-1:0] prod_reg;
    logic [CNT_W-1:0]    cnt_reg;

    // Product value after the current step, so the final step's sum can be
    // captured by the output registers on the same edge it is formed.
    assign product_next = mplier_reg[0] ? (prod_reg + mcand_reg) : prod_reg;

    // The step taken while the counter reads DATA_W-1 is the final one.
    assign last = (cnt_reg == CNT_W'(DATA_W - 1));

    // Operand/product/counter registers: load on start, advance on step.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            prod_reg   <= '0;
            cnt_reg    <= '0;
        end else if (load) begin
            mcand_reg  <= {{DATA_W{1'b0}}, a_in};
            mplier_reg <= b_in;
            prod_reg   <= '0;
            cnt_reg    <= '0;
        end else if (step) begin
            prod_reg   <= product_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU feeding the accumulator: single-cycle add/sub/inc/clear/pass
// and a DATA_W-cycle shift-add multiply. All outputs are registered.
module seq_alu
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              busy,
    output logic              carry,
    output logic              z_flag
);

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   result_reg, result_next;
    logic                carry_reg, carry_next;
    logic                z_reg, z_next;
    logic                done_reg, done_next;
    logic                busy_reg, busy_next;

    logic                mul_load;
    logic                mul_step;
    logic                mul_last;
    logic [2*DATA_W-1:0] mul_product;

    // Extended-width results so the top bit is the carry/borrow.
    logic [DATA_W:0]     add_sum;
    logic [DATA_W:0]     sub_diff;
    logic [DATA_W:0]     inc_sum;

    seq_mul #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_mul (
        .clk          (clk),
        .rst          (rst),
        .load         (mul_load),
        .step         (mul_step),
        .a_in         (a_in),
        .b_in         (b_in),
        .product_next (mul_product),
        .last         (mul_last)
    );

    // Single-cycle arithmetic; borrow falls out as the MSB of the widened difference.
    always_comb begin
        add_sum  = {1'b0, a_in} + {1'b0, b_in};
        sub_diff = {1'b0, a_in} - {1'b0, b_in};
        inc_sum  = {1'b0, a_in} + (DATA_W + 1)'(1);
    end

    // Next-state and next-output logic; everything holds unless an op completes.
    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        carry_next  = carry_reg;
        z_next      = z_reg;
        done_next   = 1'b0;
        busy_next   = busy_reg;
        mul_load    = 1'b0;
        mul_step    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mul_load   = 1'b1;
                        busy_next  = 1'b1;
                        state_next = S_MUL;
                    end else begin
                        done_next = 1'b1;
                        case (op)
                            OP_PASS: begin
                                result_next = b_in;
                                carry_next  = 1'b0;
                            end
                            OP_ADD: begin
                                result_next = add_sum[DATA_W-1:0];
                                carry_next  = add_sum[DATA_W];
                            end
                            OP_SUB: begin
                                result_next = sub_diff[DATA_W-1:0];
                                carry_next  = sub_diff[DATA_W];
                            end
                            OP_INC: begin
                                result_next = inc_sum[DATA_W-1:0];
                                carry_next  = inc_sum[DATA_W];
                            end
                            OP_CLR: begin
                                result_next = '0;
                                carry_next  = 1'b0;
                            end
                            default: begin
                                // Reserved codes: keep result and carry, still acknowledge.
                                result_next = result_reg;
                                carry_next  = carry_reg;
                            end
                        endcase
                    end
                end
            end
            S_MUL: begin
                // start/op/operands are ignored here; only the datapath advances.
                mul_step = 1'b1;
                if (mul_last) begin
                    result_next = mul_product[DATA_W-1:0];
                    carry_next  = |mul_product[2*DATA_W-1:DATA_W];
                    done_next   = 1'b1;
                    busy_next   = 1'b0;
                    state_next  = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
            end
        endcase

        // Zero flag always tracks whatever result is being registered.
        if (done_next) begin
            z_next = (result_next == '0);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            z_reg      <= 1'b0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            carry_reg  <= carry_next;
            z_reg      <= z_next;
            done_reg   <= done_next;
            busy_reg   <= busy_next;
        end
    end

    assign result = result_reg;
    assign carry  = carry_reg;
    assign z_flag = z_reg;
    assign done   = done_reg;
    assign busy   = busy_reg;

endmodule
